// File: rtl/timer_arbiter_if.sv
// Request/grant bus between client blocks and the shared countdown timer.
interface timer_arbiter_if #(
  parameter int N    = 8,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] value;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [N-1:0]      remaining;

  modport master (output req, value, input grant, done, busy, remaining);
  modport slave  (input req, value, output grant, done, busy, remaining);
endinterface

// File: rtl/timer_arbiter.sv
// One N-bit countdown timer shared round-robin between NREQ requesters.
// Optional prescaler on the decrement enabled by TIMER_ARB_PRESCALE_EN.
module timer_arbiter #(
  parameter int N        = 8,
  parameter int NREQ     = 4,
  parameter int PRESCALE = 4
) (
  input  logic            clk,
  input  logic            reset,
  timer_arbiter_if.slave  bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] pick;
  logic          found;
  logic [N-1:0]  count, count_nxt;
  logic          tick;

  // First requester after ptr, wrapping; ptr itself is searched last.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && bus.req[(int'(ptr) + k) % NREQ]) begin
        pick  = IW'((int'(ptr) + k) % NREQ);
        found = 1'b1;
      end
    end
  end

`ifdef TIMER_ARB_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] presc;

  assign tick = (presc == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              presc <= '0;
    else if (state == LOAD)  presc <= '0;
    else if (state == RUN)   presc <= tick ? '0 : presc + PW'(1);
  end
`else
  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= IW'(NREQ - 1);
      count <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    count_nxt = count;
    case (state)
      IDLE: if (found) begin
        owner_nxt = pick;
        state_nxt = LOAD;
      end
      LOAD: begin
        count_nxt = bus.value[int'(owner)*N +: N];
        state_nxt = RUN;
      end
      RUN: begin
        // Timeout takes precedence over a cancel in the same cycle.
        if (count == '0)            state_nxt = DONE;
        else if (!bus.req[owner])   state_nxt = IDLE;
        else if (tick)              count_nxt = count - N'(1);
      end
      DONE: begin
        ptr_nxt   = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.grant = '0;
    bus.done  = '0;
    if (state != IDLE) bus.grant[owner] = 1'b1;
    if (state == DONE) bus.done[owner]  = 1'b1;
  end

  assign bus.busy      = (state != IDLE);
  assign bus.remaining = (state == RUN) ? count : '0;

endmodule

// File: tb/tb_timer_arbiter.sv
// Randomised and directed checks of timer_arbiter against a timeline model.
module tb_timer_arbiter;
  localparam int N    = 8;
  localparam int NREQ = 4;
`ifdef TIMER_ARB_PRESCALE_EN
  localparam int P    = 4;
`else
  localparam int P    = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  timer_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();
  timer_arbiter #(.N(N), .NREQ(NREQ), .PRESCALE(P)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0, n_err = 0;
  int cyc_n = 0;
  int n_done = 0, last_done_cyc = -1;
  logic [NREQ-1:0] prev_g = '0;
  logic [NREQ-1:0] gq[$];

  always @(posedge clk) cyc_n++;

  // Model: owner (-1 idle) and t = cycles since grant became visible.
  // t=0 load, t=1..V*P+1 counting, t=V*P+2 done pulse.
  int m_own, m_t, m_v, m_ptr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  task automatic m_reset();
    m_own = -1; m_t = 0; m_v = 0; m_ptr = NREQ - 1;
  endtask

  function automatic int m_rem();
    if (m_own >= 0 && m_t >= 1 && m_t <= m_v*P + 1) return m_v - (m_t - 1) / P;
    return 0;
  endfunction

  task automatic m_step(input logic [NREQ-1:0] r, input logic [NREQ*N-1:0] v);
    if (m_own < 0) begin
      for (int k = 1; k <= NREQ; k++)
        if (m_own < 0 && r[(m_ptr + k) % NREQ]) m_own = (m_ptr + k) % NREQ;
      m_t = 0;
    end else if (m_t == 0) begin
      m_v = int'(v[m_own*N +: N]);
      m_t = 1;
    end else if (m_t <= m_v*P + 1) begin
      if (m_rem() != 0 && !r[m_own]) m_own = -1;
      else m_t++;
    end else begin
      m_ptr = m_own;
      m_own = -1;
    end
  endtask

  task automatic check_out();
    logic [NREQ-1:0] eg, ed;
    eg = (m_own >= 0) ? NREQ'(1 << m_own) : '0;
    ed = (m_own >= 0 && m_t == m_v*P + 2) ? eg : '0;
    chk("grant", 32'(bus.grant), 32'(eg));
    chk("done", 32'(bus.done), 32'(ed));
    chk("busy", 32'(bus.busy), 32'(m_own >= 0));
    chk("remaining", 32'(bus.remaining), 32'(m_rem()));
    if (bus.done != '0) begin n_done++; last_done_cyc = cyc_n; end
    if (bus.grant != '0 && prev_g == '0) gq.push_back(bus.grant);
    prev_g = bus.grant;
  endtask

  task automatic cyc(input logic [NREQ-1:0] r, input logic [NREQ*N-1:0] v);
    @(negedge clk);
    check_out();
    bus.req = r; bus.value = v;
    if (reset) m_step(r, v);
  endtask

  task automatic run_one(input int i, input int val, input string tag);
    int d0, base;
    logic [NREQ*N-1:0] v;
    d0 = n_done;
    v = '0;
    v[i*N +: N] = N'(val);
    cyc(NREQ'(1 << i), v);
    base = cyc_n;
    for (int k = 0; k < val*P + 10 && n_done == d0; k++) cyc(NREQ'(1 << i), v);
    chk({tag, "_done_edge"}, 32'(last_done_cyc - base), 32'(val*P + 3));
    cyc('0, v);
    cyc('0, v);
    chk({tag, "_one_pulse"}, 32'(n_done - d0), 32'd1);
  endtask

  initial begin
    logic [NREQ*N-1:0] v;
    logic [NREQ-1:0] r;
    int d0;
    m_reset();
    bus.req = '1; bus.value = '0;

    // Held in reset with every requester asking: nothing may come out.
    repeat (4) begin @(negedge clk); check_out(); end
    reset = 1'b1; bus.req = '0;

    run_one(2, 5, "single");
    run_one(3, 1, "r3");

    // Round robin from ptr=3 with 0,1,3 requesting.
    gq.delete();
    v = '0;
    for (int k = 0; k < NREQ; k++) v[k*N +: N] = N'(2);
    repeat (4*(2*P + 4) + 2) cyc(4'b1011, v);
    chk("rr_0", (gq.size() > 0) ? 32'(gq[0]) : 32'h0, 32'h1);
    chk("rr_1", (gq.size() > 1) ? 32'(gq[1]) : 32'h0, 32'h2);
    chk("rr_2", (gq.size() > 2) ? 32'(gq[2]) : 32'h0, 32'h8);
    chk("rr_3", (gq.size() > 3) ? 32'(gq[3]) : 32'h0, 32'h1);
    repeat (2*P + 8) cyc('0, v);

    // Cancel at remaining=6, pointer must stay at 3.
    run_one(3, 2, "r3b");
    v = '0;
    v[1*N +: N] = N'(10);
    d0 = n_done;
    for (int k = 0; k < 60; k++) begin
      if (m_own == 1 && m_t >= 1 && m_rem() == 6) break;
      cyc(4'b0010, v);
    end
    cyc(4'b0000, v);
    chk("cancel_rem6_seen", 32'(bus.remaining), 32'd6);
    cyc(4'b0000, v);
    chk("cancel_idle", 32'(bus.busy), 32'd0);
    chk("cancel_no_done", 32'(n_done - d0), 32'd0);
    gq.delete();
    v[0*N +: N] = N'(1); v[1*N +: N] = N'(1);
    for (int k = 0; k < P + 10 && n_done == d0; k++) cyc(4'b0011, v);
    repeat (3) cyc('0, v);
    chk("cancel_next_grant", (gq.size() > 0) ? 32'(gq[0]) : 32'h0, 32'h1);

    run_one(0, 0, "v0");
    run_one(2, 255, "vff");

    // Request dropped in the very cycle the count hits zero.
    v = '0;
    v[3*N +: N] = N'(3);
    d0 = n_done;
    for (int k = 0; k < 50; k++) begin
      if (m_own == 3 && m_t >= 1 && m_rem() == 0) break;
      cyc(4'b1000, v);
    end
    cyc(4'b0000, v);
    repeat (3) cyc(4'b0000, v);
    chk("drop_at_zero_done", 32'(n_done - d0), 32'd1);

    // Asynchronous reset in the middle of a count.
    v = '0;
    v[0*N +: N] = N'(20);
    d0 = n_done;
    for (int k = 0; k < 60; k++) begin
      if (m_own == 0 && m_t == 5) break;
      cyc(4'b0001, v);
    end
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_grant", 32'(bus.grant), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_rem", 32'(bus.remaining), 32'd0);
    chk("rst_mid_done", 32'(bus.done), 32'd0);
    m_reset();
    cyc(4'b0001, v);
    cyc(4'b0000, v);
    reset = 1'b1;
    repeat (2) cyc(4'b0000, v);
    chk("rst_mid_no_done", 32'(n_done - d0), 32'd0);

    // Random traffic: sparse request toggles, values re-randomised every cycle.
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) r ^= NREQ'(1 << $urandom_range(0, NREQ - 1));
      for (int k = 0; k < NREQ; k++) v[k*N +: N] = N'($urandom_range(0, 9));
      cyc(r, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
